// File: rtl/dest_tag_pipe_if.sv
// dest_tag_pipe_if: (dest, RegWrite) tags of the ID/EX, EX/MEM and MEM/WB slots, fed to the hazard unit.
interface dest_tag_pipe_if;
  logic [4:0] ID_EX_dest;
  logic       ID_EX_RegWrite;
  logic [4:0] EX_MEM_wr_reg;
  logic       EX_MEM_RegWrite;
  logic [4:0] MEM_WB_wr_reg;
  logic       MEM_WB_RegWrite;
  modport master (output ID_EX_dest, ID_EX_RegWrite, EX_MEM_wr_reg, EX_MEM_RegWrite, MEM_WB_wr_reg, MEM_WB_RegWrite);
  modport slave  (input  ID_EX_dest, ID_EX_RegWrite, EX_MEM_wr_reg, EX_MEM_RegWrite, MEM_WB_wr_reg, MEM_WB_RegWrite);
endinterface

// File: rtl/dest_tag_pipe.sv
// dest_tag_pipe: decodes the ID destination register and carries its tag through ID/EX, EX/MEM, MEM/WB with scoreboard and stall watchdog.
// Defining STALL_STATS_EN adds the saturating stall_cycles counter port.
module dest_tag_pipe #(
  parameter int MAX_STALL = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic             stall_in,
  input  logic             flush_in,
  dest_tag_pipe_if.master  tags,
  output logic [31:0]      busy_vec,
  output logic             stall_timeout
`ifdef STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                         OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e,
                         OP_LUI = 6'h0f, OP_LW = 6'h23;
  localparam logic [5:0] FN_JR = 6'h08;
  if (MAX_STALL < 2 || MAX_STALL > 255 || CNT_W < 1) begin : g_bad_param
    $error("dest_tag_pipe: MAX_STALL must be 2..255 and CNT_W at least 1");
  end
  logic [4:0] dec_dest, tag_dest;
  logic       dec_wr, tag_wr;
  logic [4:0] id_ex_dest_q, id_ex_dest_d, ex_mem_dest_q, ex_mem_dest_d, mem_wb_dest_q, mem_wb_dest_d;
  logic       id_ex_wr_q, id_ex_wr_d, ex_mem_wr_q, ex_mem_wr_d, mem_wb_wr_q, mem_wb_wr_d;
  logic [7:0] run_q, run_d;
  logic       timeout_q, timeout_d;
  always_comb begin
    dec_dest = 5'd0;
    dec_wr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin dec_dest = rd; dec_wr = funct != FN_JR; end
      OP_LW, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin dec_dest = rt; dec_wr = 1'b1; end
      OP_JAL: begin dec_dest = 5'd31; dec_wr = 1'b1; end
      default: ;
    endcase
    // $0 is never tagged, and a non-writing instruction carries no dest
    tag_wr   = dec_wr && dec_dest != 5'd0;
    tag_dest = tag_wr ? dec_dest : 5'd0;
  end
  always_comb begin
    id_ex_wr_d    = tag_wr && instr_valid && !stall_in && !flush_in;
    id_ex_dest_d  = id_ex_wr_d ? tag_dest : 5'd0;
    ex_mem_dest_d = id_ex_dest_q;
    ex_mem_wr_d   = id_ex_wr_q;
    mem_wb_dest_d = ex_mem_dest_q;
    mem_wb_wr_d   = ex_mem_wr_q;
    run_d         = !stall_in ? 8'd0 : (&run_q ? run_q : run_q + 8'd1);
    timeout_d     = stall_in && run_q == 8'(MAX_STALL - 1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_dest_q  <= '0;
      id_ex_wr_q    <= 1'b0;
      ex_mem_dest_q <= '0;
      ex_mem_wr_q   <= 1'b0;
      mem_wb_dest_q <= '0;
      mem_wb_wr_q   <= 1'b0;
      run_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      id_ex_dest_q  <= id_ex_dest_d;
      id_ex_wr_q    <= id_ex_wr_d;
      ex_mem_dest_q <= ex_mem_dest_d;
      ex_mem_wr_q   <= ex_mem_wr_d;
      mem_wb_dest_q <= mem_wb_dest_d;
      mem_wb_wr_q   <= mem_wb_wr_d;
      run_q         <= run_d;
      timeout_q     <= timeout_d;
    end
  end
`ifdef STALL_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  always_comb stall_cycles_d = (stall_in && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
`endif
  assign tags.ID_EX_dest      = id_ex_dest_q;
  assign tags.ID_EX_RegWrite  = id_ex_wr_q;
  assign tags.EX_MEM_wr_reg   = ex_mem_dest_q;
  assign tags.EX_MEM_RegWrite = ex_mem_wr_q;
  assign tags.MEM_WB_wr_reg   = mem_wb_dest_q;
  assign tags.MEM_WB_RegWrite = mem_wb_wr_q;
  assign stall_timeout        = timeout_q;
  assign busy_vec = ((32'(id_ex_wr_q) << id_ex_dest_q) | (32'(ex_mem_wr_q) << ex_mem_dest_q)
                   | (32'(mem_wb_wr_q) << mem_wb_dest_q)) & ~32'h1;
endmodule
